// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern controller: register map,
// animation mode encodings, FSM states and bounce direction values.
package led_pattern_pkg;

  // Avalon-MM word addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_PATTERN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_LEDSTAT = 3'd3;
  localparam logic [2:0] ADDR_STEPCNT = 3'd4;

  // CTRL[2:1] animation mode
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } led_mode_t;

  // Controller FSM: IDLE while CTRL.EN=0, RUN while CTRL.EN=1
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } led_state_t;

  // Bounce direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int STEPCNT_W = 16;

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: counts 0..P-1 (P = period, period 0 behaves as 1) while
// enabled and pulses tick for one cycle on the terminal count. A clear
// restarts the count and suppresses any tick in that cycle.
module led_step_timer #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last;
  logic                at_last;

  // Terminal count; >= keeps the counter bounded if PERIOD shrinks mid-count
  assign last    = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign at_last = (count >= last);
  assign tick    = enable && !clear && at_last;

  // Prescaler: held at 0 when disabled or cleared, wraps after the terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable || at_last) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Avalon-MM LED pattern controller. Software loads a pattern, step period
// and mode; in RUN the working register is animated once per step tick.
// Bus handshake: a write is accepted in any cycle with chipselect && write;
// a read is taken with chipselect && read && !write and its data appears on
// readdata the following cycle; readdata is 0 in every other cycle.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  led_state_t          state, state_nxt;
  led_mode_t           mode, mode_nxt;
  logic [NUM_LEDS-1:0] pattern, pattern_src;
  logic [PERIOD_W-1:0] period;
  logic [NUM_LEDS-1:0] work, work_nxt, led_nxt;
  logic                phase, phase_nxt;
  logic                dir, dir_nxt;
  logic [STEPCNT_W-1:0] stepcnt;
  logic [31:0]         rd_mux;
  logic                wr_en, rd_en, ctrl_wr, pat_wr, per_wr, cnt_clr, reload;
  logic                run, tick;
  logic                unused_wdata;

  // Upper writedata bits beyond the register widths are intentionally dropped
  assign unused_wdata = ^writedata;

  // Bus decode; a simultaneous read and write counts only as a write
  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && read && !write;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);
  assign pat_wr  = wr_en && (address == ADDR_PATTERN);
  assign per_wr  = wr_en && (address == ADDR_PERIOD);
  assign cnt_clr = wr_en && (address == ADDR_STEPCNT);
  assign reload  = ctrl_wr || pat_wr;

  assign run         = (state == ST_RUN);
  assign pattern_src = pat_wr ? writedata[NUM_LEDS-1:0] : pattern;
  assign mode_nxt    = ctrl_wr ? led_mode_t'(writedata[2:1]) : mode;

  // A reload clears the prescaler, which also discards a coincident tick
  led_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (run),
    .clear   (reload),
    .period  (period),
    .tick    (tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: follows EN of each CTRL write
  always_comb begin
    state_nxt = state;
    if (ctrl_wr) state_nxt = writedata[0] ? ST_RUN : ST_IDLE;
  end

  // FSM output: LED drive for the next cycle, dark in IDLE and blink-off phase
  always_comb begin
    led_nxt = '0;
    if (state_nxt == ST_RUN && !(mode_nxt == MODE_BLINK && phase_nxt))
      led_nxt = work_nxt;
  end

  // Working-register animation: reload wins over a tick
  always_comb begin
    work_nxt  = work;
    phase_nxt = phase;
    dir_nxt   = dir;
    if (reload) begin
      work_nxt  = pattern_src;
      phase_nxt = 1'b0;
      dir_nxt   = DIR_LEFT;
    end else if (tick) begin
      case (mode)
        MODE_STATIC: ;
        MODE_BLINK:  phase_nxt = ~phase;
        MODE_ROTATE: work_nxt = (work << 1) | (work >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          if (dir == DIR_LEFT) begin
            if (work[NUM_LEDS-1]) begin
              dir_nxt  = DIR_RIGHT;
              work_nxt = work >> 1;
            end else begin
              work_nxt = work << 1;
            end
          end else begin
            if (work[0]) begin
              dir_nxt  = DIR_LEFT;
              work_nxt = work << 1;
            end else begin
              work_nxt = work >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Software-visible registers, animation state and registered LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode    <= MODE_STATIC;
      pattern <= '0;
      period  <= '0;
      work    <= '0;
      phase   <= 1'b0;
      dir     <= DIR_LEFT;
      led_out <= '0;
    end else begin
      mode    <= mode_nxt;
      if (pat_wr) pattern <= writedata[NUM_LEDS-1:0];
      if (per_wr) period  <= writedata[PERIOD_W-1:0];
      work    <= work_nxt;
      phase   <= phase_nxt;
      dir     <= dir_nxt;
      led_out <= led_nxt;
    end
  end

  // Step counter: write-to-clear beats a coincident tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     stepcnt <= '0;
    else if (cnt_clr) stepcnt <= '0;
    else if (tick)    stepcnt <= stepcnt + STEPCNT_W'(1);
  end

  // Read mux; unmapped addresses return 0
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:    rd_mux = {29'd0, mode, run};
      ADDR_PATTERN: rd_mux = 32'(pattern);
      ADDR_PERIOD:  rd_mux = 32'(period);
      ADDR_LEDSTAT: rd_mux = 32'(led_out);
      ADDR_STEPCNT: rd_mux = 32'(stepcnt);
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, zero outside the cycle after an accepted read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_en ? rd_mux : '0;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (NUM_LEDS=10, PERIOD_W=26).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  led_out;

  int          n_assert;
  int          n_fail;
  logic [31:0] rd;
  logic [31:0] e;
  logic [31:0] rot_exp [5];

  led_pattern_ctrl #(.NUM_LEDS(10), .PERIOD_W(26)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  // Called at a falling edge; returns the registered read data one cycle later
  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rot_exp  = '{32'h201, 32'h003, 32'h006, 32'h00C, 32'h018};
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 5; a++) begin
      bus_rd(3'(a), rd);
      chk($sformatf("rst_reg%0d", a), rd, 32'h0);
    end

    // STATIC: upper pattern bits dropped, LEDs lit one cycle after CTRL write
    bus_wr(3'd1, 32'hABCD_E155);
    bus_wr(3'd0, 32'h1);
    chk("static_led", 32'(led_out), 32'h155);
    bus_rd(3'd3, rd);
    chk("static_ledstat", rd, 32'h155);
    @(negedge clk);
    chk("rdata_back_to_0", readdata, 32'h0);
    chk("static_ignores_tick", 32'(led_out), 32'h155);
    bus_rd(3'd1, rd);
    chk("pattern_trunc", rd, 32'h155);

    // BLINK with PERIOD=3
    bus_wr(3'd0, 32'h0);
    chk("idle_led", 32'(led_out), 32'h0);
    bus_wr(3'd4, 32'h0);
    bus_wr(3'd2, 32'hFC00_0003);
    bus_rd(3'd2, rd);
    chk("period_trunc", rd, 32'h3);
    bus_wr(3'd1, 32'h2AA);
    bus_wr(3'd0, 32'h3);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      e = (((k / 3) % 2) == 0) ? 32'h2AA : 32'h0;
      chk($sformatf("blink_k%0d", k), 32'(led_out), e);
    end
    bus_rd(3'd4, rd);
    chk("blink_stepcnt", rd, 32'h2);

    // ROTATE with PERIOD=1, then PERIOD=0 gives the same sequence
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd1, 32'h201);
    bus_wr(3'd0, 32'h5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("rot_p1_%0d", i), 32'(led_out), rot_exp[i]);
    end
    bus_wr(3'd2, 32'h0);
    bus_wr(3'd0, 32'h5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("rot_p0_%0d", i), 32'(led_out), rot_exp[i]);
    end

    // BOUNCE with PERIOD=1: 0x001 up to 0x200, back to 0x001, then up again
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd1, 32'h1);
    bus_wr(3'd0, 32'h7);
    for (int k = 0; k < 21; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 9)       e = 32'd1 << k;
      else if (k <= 18) e = 32'd1 << (18 - k);
      else              e = 32'd1 << (k - 18);
      chk($sformatf("bounce_k%0d", k), 32'(led_out), e);
    end

    // Collisions: pattern write on a tick cycle, STEPCNT clear on a tick
    bus_wr(3'd1, 32'h0F0);
    chk("pat_wr_on_tick", 32'(led_out), 32'h0F0);
    @(negedge clk);
    chk("after_pat_wr_tick", 32'(led_out), 32'h1E0);
    bus_wr(3'd4, 32'h0);
    bus_rd(3'd4, rd);
    chk("stepcnt_clr_on_tick", rd, 32'h0);
    bus_wr(3'd6, 32'hFFFF_FFFF);
    bus_rd(3'd6, rd);
    chk("addr6_reads_0", rd, 32'h0);
    bus_rd(3'd0, rd);
    chk("ctrl_readback", rd, 32'h7);

    // Simultaneous read and write behaves as a write only
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd2; writedata = 32'h5;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
    chk("rdwr_rdata", readdata, 32'h0);
    bus_rd(3'd2, rd);
    chk("rdwr_period", rd, 32'h5);

    // Reset asserted mid-ROTATE while a read is in flight
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd1, 32'h201);
    bus_wr(3'd0, 32'h5);
    repeat (3) @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 3'd3;
    @(posedge clk);
    #2;
    chk("pre_rst_rdata", readdata, 32'h00C);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led_out), 32'h0);
    chk("mid_rst_rdata", readdata, 32'h0);
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_led", 32'(led_out), 32'h0);
    for (int a = 0; a < 5; a++) begin
      bus_rd(3'(a), rd);
      chk($sformatf("post_rst_reg%0d", a), rd, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
